// File: rtl/decode_stage.sv
// MIPS-subset ID stage: GPR file, decode, branch/jump resolution with M-stage
// forwarding, load-use/branch hazard stall, and the ID/EX pipeline register.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC1,
  input  logic [31:0] Instr1,
  input  logic        IntReq,
  input  logic        RegWrite_W,
  input  logic [4:0]  A3_W,
  input  logic [31:0] WD_W,
  input  logic        RegWrite_E,
  input  logic        MemRead_E,
  input  logic [4:0]  A3_E,
  input  logic        RegWrite_M,
  input  logic        MemRead_M,
  input  logic [4:0]  A3_M,
  input  logic [31:0] ALURes_M,
  output logic [2:0]  PCSel,
  output logic [31:0] PC_beq,
  output logic [31:0] PC_j,
  output logic [31:0] PC_jr,
  output logic        PC_En,
  output logic        IF_ID_En,
  output logic        IF_ID_Clr,
  output logic [31:0] PC2,
  output logic [31:0] Instr2,
  output logic [31:0] RD1_2,
  output logic [31:0] RD2_2,
  output logic [31:0] Ext2,
  output logic [31:0] PC8_2,
  output logic [4:0]  A3_2,
  output logic        RegWrite2,
  output logic        MemRead2,
  output logic        MemWrite2
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
  localparam logic [31:0] ERET = 32'h42000018;

  logic [31:0] r_gpr [32];

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_sext, w_gpr_rs, w_gpr_rt, w_rs_val, w_rt_val, w_ext;
  logic        w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_eret;
  logic        w_use_rs, w_use_rt, w_br, w_hit_e, w_hit_m, w_stall;
  logic        w_rw, w_mr, w_mw;
  logic [4:0]  w_a3;

  assign w_op  = Instr1[31:26];
  assign w_rs  = Instr1[25:21];
  assign w_rt  = Instr1[20:16];
  assign w_rd  = Instr1[15:11];
  assign w_fn  = Instr1[5:0];
  assign w_imm = Instr1[15:0];
  assign w_sext = {{16{w_imm[15]}}, w_imm};

  assign w_addu = (w_op == OP_R) && (w_fn == FN_ADDU);
  assign w_subu = (w_op == OP_R) && (w_fn == FN_SUBU);
  assign w_jr   = (w_op == OP_R) && (w_fn == FN_JR);
  assign w_ori  = (w_op == OP_ORI);
  assign w_lui  = (w_op == OP_LUI);
  assign w_lw   = (w_op == OP_LW);
  assign w_sw   = (w_op == OP_SW);
  assign w_beq  = (w_op == OP_BEQ);
  assign w_j    = (w_op == OP_J);
  assign w_jal  = (w_op == OP_JAL);
  assign w_eret = (Instr1 == ERET);

  assign w_use_rs = w_addu | w_subu | w_ori | w_lw | w_sw | w_beq | w_jr;
  assign w_use_rt = w_addu | w_subu | w_sw | w_beq;
  assign w_br     = w_beq | w_jr;

  // GPR read with write-through of the writeback port
  assign w_gpr_rs = (w_rs == 5'd0) ? 32'd0 :
                    (RegWrite_W && A3_W == w_rs) ? WD_W : r_gpr[w_rs];
  assign w_gpr_rt = (w_rt == 5'd0) ? 32'd0 :
                    (RegWrite_W && A3_W == w_rt) ? WD_W : r_gpr[w_rt];
  assign w_rs_val = (RegWrite_M && !MemRead_M && A3_M == w_rs && w_rs != 5'd0) ? ALURes_M : w_gpr_rs;
  assign w_rt_val = (RegWrite_M && !MemRead_M && A3_M == w_rt && w_rt != 5'd0) ? ALURes_M : w_gpr_rt;

  assign w_hit_e = (A3_E != 5'd0) && ((w_use_rs && w_rs == A3_E) || (w_use_rt && w_rt == A3_E));
  assign w_hit_m = (A3_M != 5'd0) && ((w_use_rs && w_rs == A3_M) || (w_use_rt && w_rt == A3_M));
  assign w_stall = (w_hit_e && MemRead_E) || (w_br && w_hit_e && RegWrite_E) ||
                   (w_br && w_hit_m && MemRead_M);

  assign PC_beq = PC1 + 32'd4 + {w_sext[29:0], 2'b00};
  assign PC_j   = {PC1[31:28], Instr1[25:0], 2'b00};
  assign PC_jr  = w_rs_val;

  assign PC_En     = !w_stall;
  assign IF_ID_En  = !w_stall;
  assign IF_ID_Clr = !IntReq && !w_stall && w_eret;

  always_comb begin
    PCSel = 3'b000;
    if (IntReq)                              PCSel = 3'b101;
    else if (w_stall)                        PCSel = 3'b000;
    else if (w_eret)                         PCSel = 3'b111;
    else if (w_beq && w_rs_val == w_rt_val)  PCSel = 3'b001;
    else if (w_j || w_jal)                   PCSel = 3'b010;
    else if (w_jr)                           PCSel = 3'b011;
  end

  always_comb begin
    w_ext = 32'd0;
    if (w_ori)                      w_ext = {16'd0, w_imm};
    else if (w_lui)                 w_ext = {w_imm, 16'd0};
    else if (w_lw || w_sw || w_beq) w_ext = w_sext;
    w_a3 = 5'd0;
    if (w_addu || w_subu)             w_a3 = w_rd;
    else if (w_ori || w_lui || w_lw)  w_a3 = w_rt;
    else if (w_jal)                   w_a3 = 5'd31;
    w_rw = w_addu | w_subu | w_ori | w_lui | w_lw | w_jal;
    w_mr = w_lw;
    w_mw = w_sw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= 32'd0;
    end else if (RegWrite_W && A3_W != 5'd0) begin
      r_gpr[A3_W] <= WD_W;
    end
  end

  // ID/EX register; interrupts and stalls both insert a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || IntReq || w_stall) begin
      PC2 <= RESET_PC;  Instr2 <= 32'd0; RD1_2 <= 32'd0; RD2_2 <= 32'd0;
      Ext2 <= 32'd0;    PC8_2 <= 32'd0;  A3_2 <= 5'd0;
      RegWrite2 <= 1'b0; MemRead2 <= 1'b0; MemWrite2 <= 1'b0;
    end else begin
      PC2 <= PC1;       Instr2 <= Instr1; RD1_2 <= w_rs_val; RD2_2 <= w_rt_val;
      Ext2 <= w_ext;    PC8_2 <= PC1 + 32'd8; A3_2 <= w_a3;
      RegWrite2 <= w_rw; MemRead2 <= w_mr; MemWrite2 <= w_mw;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: combinational vector table, registered
// decode table, and hand-written multi-cycle hazard/reset sequences.
module tb_decode_stage;
  logic        clk, reset, IntReq;
  logic [31:0] PC1, Instr1, WD_W, ALURes_M;
  logic        RegWrite_W, RegWrite_E, MemRead_E, RegWrite_M, MemRead_M;
  logic [4:0]  A3_W, A3_E, A3_M;
  logic [2:0]  PCSel;
  logic [31:0] PC_beq, PC_j, PC_jr, PC2, Instr2, RD1_2, RD2_2, Ext2, PC8_2;
  logic        PC_En, IF_ID_En, IF_ID_Clr, RegWrite2, MemRead2, MemWrite2;
  logic [4:0]  A3_2;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.RESET_PC(32'h00003000)) dut (
    .clk(clk), .reset(reset), .PC1(PC1), .Instr1(Instr1), .IntReq(IntReq),
    .RegWrite_W(RegWrite_W), .A3_W(A3_W), .WD_W(WD_W),
    .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .A3_E(A3_E),
    .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .A3_M(A3_M), .ALURes_M(ALURes_M),
    .PCSel(PCSel), .PC_beq(PC_beq), .PC_j(PC_j), .PC_jr(PC_jr),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .IF_ID_Clr(IF_ID_Clr),
    .PC2(PC2), .Instr2(Instr2), .RD1_2(RD1_2), .RD2_2(RD2_2), .Ext2(Ext2), .PC8_2(PC8_2),
    .A3_2(A3_2), .RegWrite2(RegWrite2), .MemRead2(MemRead2), .MemWrite2(MemWrite2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    IntReq = 0; RegWrite_W = 0; A3_W = 0; WD_W = 0;
    RegWrite_E = 0; MemRead_E = 0; A3_E = 0;
    RegWrite_M = 0; MemRead_M = 0; A3_M = 0; ALURes_M = 0;
  endtask

  typedef struct {
    logic [31:0] pc, instr;
    logic intreq, rwe, mre; logic [4:0] a3e;
    logic rwm, mrm; logic [4:0] a3m; logic [31:0] alum;
    logic [2:0] sel; logic [31:0] beq, j, jr; logic en, clr;
  } cvec_t;

  typedef struct {
    logic [31:0] pc, instr;
    logic [4:0] a3; logic rw, mr, mw;
    logic [31:0] ext, rd1, rd2;
  } rvec_t;

  cvec_t cv[14];
  rvec_t rv[7];

  initial begin
    cv[0]  = '{32'h3010, 32'h10430004, 0,0,0,5'd0, 1,0,5'd2, 32'h7,        3'b001, 32'h3024, 32'h010C0010, 32'h7,        1,0};
    cv[1]  = '{32'h3010, 32'h10430004, 0,0,0,5'd0, 0,0,5'd0, 32'h0,        3'b000, 32'h3024, 32'h010C0010, 32'h0,        1,0};
    cv[2]  = '{32'h3010, 32'h1000FFFF, 0,0,0,5'd0, 0,0,5'd0, 32'h0,        3'b001, 32'h3010, 32'h0003FFFC, 32'h0,        1,0};
    cv[3]  = '{32'hA0003010, 32'h08000100, 0,0,0,5'd0, 0,0,5'd0, 32'h0,    3'b010, 32'hA0003414, 32'hA0000400, 32'h0,    1,0};
    cv[4]  = '{32'h3000, 32'h0C000100, 0,0,0,5'd0, 0,0,5'd0, 32'h0,        3'b010, 32'h3404, 32'h00000400, 32'h0,        1,0};
    cv[5]  = '{32'h3000, 32'h01200008, 0,0,0,5'd0, 0,0,5'd0, 32'h0,        3'b011, 32'h3024, 32'h04800020, 32'h55,       1,0};
    cv[6]  = '{32'h3000, 32'h01200008, 0,0,0,5'd0, 1,0,5'd9, 32'hDEAD0000, 3'b011, 32'h3024, 32'h04800020, 32'hDEAD0000, 1,0};
    cv[7]  = '{32'h3000, 32'h01200008, 0,0,0,5'd0, 1,1,5'd9, 32'hDEAD0000, 3'b000, 32'h3024, 32'h04800020, 32'h55,       0,0};
    cv[8]  = '{32'h3000, 32'h42000018, 0,0,0,5'd0, 0,0,5'd0, 32'h0,        3'b111, 32'h3064, 32'h08000060, 32'h0,        1,1};
    cv[9]  = '{32'h3010, 32'h10430004, 1,0,0,5'd0, 1,0,5'd2, 32'h7,        3'b101, 32'h3024, 32'h010C0010, 32'h7,        1,0};
    cv[10] = '{32'h3000, 32'h00843821, 0,1,1,5'd4, 0,0,5'd0, 32'h0,        3'b000, 32'h11088, 32'h0210E084, 32'h0,       0,0};
    cv[11] = '{32'h3010, 32'h10430004, 0,1,0,5'd3, 0,0,5'd0, 32'h0,        3'b000, 32'h3024, 32'h010C0010, 32'h0,        0,0};
    cv[12] = '{32'h3000, 32'h00843821, 0,1,0,5'd4, 0,0,5'd0, 32'h0,        3'b000, 32'h11088, 32'h0210E084, 32'h0,       1,0};
    cv[13] = '{32'h3000, 32'h8C010000, 0,1,1,5'd0, 0,0,5'd0, 32'h0,        3'b000, 32'h3004, 32'h00040000, 32'h0,        1,0};

    rv[0] = '{32'h3000, 32'h34088001, 5'd8,  1,0,0, 32'h00008001, 32'h0,    32'h0};
    rv[1] = '{32'h3004, 32'h3C088001, 5'd8,  1,0,0, 32'h80010000, 32'h0,    32'h0};
    rv[2] = '{32'h3100, 32'hAD23FFFC, 5'd0,  0,0,1, 32'hFFFFFFFC, 32'h55,   32'h7};
    rv[3] = '{32'h3200, 32'h0C000100, 5'd31, 1,0,0, 32'h0,        32'h0,    32'h0};
    rv[4] = '{32'h3300, 32'hFC000000, 5'd0,  0,0,0, 32'h0,        32'h0,    32'h0};
    rv[5] = '{32'h3400, 32'h01235023, 5'd10, 1,0,0, 32'h0,        32'h55,   32'h7};
    rv[6] = '{32'h3500, 32'h8CA1FFF8, 5'd1,  1,1,0, 32'hFFFFFFF8, 32'h1234, 32'h0};

    // reset: ID/EX clears asynchronously, then lw decodes after release
    quiet();
    reset = 1; PC1 = 32'h3000; Instr1 = 32'h8C010000;
    #1 reset = 0;
    #1;
    chk("rst_RD1_2", RD1_2, 32'h0);
    chk("rst_PC2", PC2, 32'h3000);
    chk("rst_A3_2", {27'd0, A3_2}, 32'h0);
    step(); step();
    reset = 1;
    step();
    chk("lw_A3_2", {27'd0, A3_2}, 32'd1);
    chk("lw_MemRead2", {31'd0, MemRead2}, 32'd1);
    chk("lw_RegWrite2", {31'd0, RegWrite2}, 32'd1);
    chk("lw_PC8_2", PC8_2, 32'h3008);

    // preload $3=7, $9=0x55, and an ignored write to $0
    Instr1 = 32'h0;
    RegWrite_W = 1; A3_W = 3; WD_W = 32'h7; step();
    A3_W = 9; WD_W = 32'h55; step();
    A3_W = 0; WD_W = 32'hFFFF; step();
    RegWrite_W = 0;
    Instr1 = 32'h00033021; step();
    chk("r0_RD1_2", RD1_2, 32'h0);
    chk("r3_RD2_2", RD2_2, 32'h7);

    // write-through: $5 written in the same cycle addu $6,$5,$0 reads it
    Instr1 = 32'h00A03021; RegWrite_W = 1; A3_W = 5; WD_W = 32'h1234;
    step();
    RegWrite_W = 0;
    chk("wt_RD1_2", RD1_2, 32'h1234);
    chk("wt_A3_2", {27'd0, A3_2}, 32'd6);

    for (int i = 0; i < 14; i++) begin
      quiet();
      PC1 = cv[i].pc; Instr1 = cv[i].instr; IntReq = cv[i].intreq;
      RegWrite_E = cv[i].rwe; MemRead_E = cv[i].mre; A3_E = cv[i].a3e;
      RegWrite_M = cv[i].rwm; MemRead_M = cv[i].mrm; A3_M = cv[i].a3m; ALURes_M = cv[i].alum;
      #1;
      chk($sformatf("cv%0d_PCSel", i), {29'd0, PCSel}, {29'd0, cv[i].sel});
      chk($sformatf("cv%0d_PC_beq", i), PC_beq, cv[i].beq);
      chk($sformatf("cv%0d_PC_j", i), PC_j, cv[i].j);
      chk($sformatf("cv%0d_PC_jr", i), PC_jr, cv[i].jr);
      chk($sformatf("cv%0d_PC_En", i), {31'd0, PC_En}, {31'd0, cv[i].en});
      chk($sformatf("cv%0d_IF_ID_En", i), {31'd0, IF_ID_En}, {31'd0, cv[i].en});
      chk($sformatf("cv%0d_IF_ID_Clr", i), {31'd0, IF_ID_Clr}, {31'd0, cv[i].clr});
    end

    quiet();
    for (int i = 0; i < 7; i++) begin
      PC1 = rv[i].pc; Instr1 = rv[i].instr;
      step();
      chk($sformatf("rv%0d_A3_2", i), {27'd0, A3_2}, {27'd0, rv[i].a3});
      chk($sformatf("rv%0d_RegWrite2", i), {31'd0, RegWrite2}, {31'd0, rv[i].rw});
      chk($sformatf("rv%0d_MemRead2", i), {31'd0, MemRead2}, {31'd0, rv[i].mr});
      chk($sformatf("rv%0d_MemWrite2", i), {31'd0, MemWrite2}, {31'd0, rv[i].mw});
      chk($sformatf("rv%0d_Ext2", i), Ext2, rv[i].ext);
      chk($sformatf("rv%0d_RD1_2", i), RD1_2, rv[i].rd1);
      chk($sformatf("rv%0d_RD2_2", i), RD2_2, rv[i].rd2);
      chk($sformatf("rv%0d_PC2", i), PC2, rv[i].pc);
      chk($sformatf("rv%0d_PC8_2", i), PC8_2, rv[i].pc + 32'd8);
      chk($sformatf("rv%0d_Instr2", i), Instr2, rv[i].instr);
    end

    // load-use: lw $4 in EX, addu $7,$4,$4 in ID -> one bubble
    quiet();
    PC1 = 32'h3020; Instr1 = 32'h00843821;
    RegWrite_E = 1; MemRead_E = 1; A3_E = 4;
    #1;
    chk("lu_PC_En", {31'd0, PC_En}, 32'd0);
    chk("lu_IF_ID_En", {31'd0, IF_ID_En}, 32'd0);
    step();
    chk("lu_bub_A3_2", {27'd0, A3_2}, 32'd0);
    chk("lu_bub_PC2", PC2, 32'h3000);
    chk("lu_bub_Instr2", Instr2, 32'h0);
    quiet();
    RegWrite_M = 1; MemRead_M = 1; A3_M = 4;
    #1;
    chk("lu2_PC_En", {31'd0, PC_En}, 32'd1);
    step();
    chk("lu2_A3_2", {27'd0, A3_2}, 32'd7);
    chk("lu2_PC2", PC2, 32'h3020);

    // jr $31 with producer in EX -> one stall, then M forward
    quiet();
    Instr1 = 32'h03E00008; RegWrite_E = 1; A3_E = 31;
    #1;
    chk("jr_stall_PC_En", {31'd0, PC_En}, 32'd0);
    chk("jr_stall_PCSel", {29'd0, PCSel}, 32'd0);
    step();
    quiet();
    RegWrite_M = 1; A3_M = 31; ALURes_M = 32'h00004000;
    #1;
    chk("jr_go_PC_En", {31'd0, PC_En}, 32'd1);
    chk("jr_go_PCSel", {29'd0, PCSel}, 32'd3);
    chk("jr_go_PC_jr", PC_jr, 32'h00004000);
    step();

    // beq $4,$3 behind lw $4: (b) then (c) gives two stall cycles
    quiet();
    PC1 = 32'h3040; Instr1 = 32'h10830001;
    RegWrite_E = 1; MemRead_E = 1; A3_E = 4;
    #1;
    chk("ch1_PC_En", {31'd0, PC_En}, 32'd0);
    step();
    quiet();
    RegWrite_M = 1; MemRead_M = 1; A3_M = 4;
    #1;
    chk("ch2_PC_En", {31'd0, PC_En}, 32'd0);
    chk("ch2_PCSel", {29'd0, PCSel}, 32'd0);
    step();
    quiet();
    RegWrite_W = 1; A3_W = 4; WD_W = 32'h7;
    #1;
    chk("ch3_PC_En", {31'd0, PC_En}, 32'd1);
    chk("ch3_PCSel", {29'd0, PCSel}, 32'd1);
    chk("ch3_PC_beq", PC_beq, 32'h3048);
    step();

    // IntReq with taken beq: exception vector and ID/EX bubble
    quiet();
    PC1 = 32'h3010; Instr1 = 32'h10430004;
    RegWrite_M = 1; A3_M = 2; ALURes_M = 32'h7; IntReq = 1;
    #1;
    chk("int_PCSel", {29'd0, PCSel}, 32'd5);
    step();
    chk("int_A3_2", {27'd0, A3_2}, 32'd0);
    chk("int_RegWrite2", {31'd0, RegWrite2}, 32'd0);
    chk("int_Ext2", Ext2, 32'h0);
    chk("int_PC2", PC2, 32'h3000);

    // reset asserted mid-cycle while a stall is pending
    quiet();
    PC1 = 32'h3400; Instr1 = 32'h01235023;
    step();
    chk("pre_A3_2", {27'd0, A3_2}, 32'd10);
    Instr1 = 32'h01200008; RegWrite_E = 1; A3_E = 9;
    #1 reset = 0;
    #1;
    chk("mrst_A3_2", {27'd0, A3_2}, 32'd0);
    chk("mrst_PC2", PC2, 32'h3000);
    chk("mrst_gpr9", PC_jr, 32'h0);
    reset = 1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage sitting directly downstream of the fetch stage's IF/ID register. Owns the 32×32 GPR file, decodes the supported MIPS subset, and resolves branches and jumps in ID using M-stage forwarding. It drives the fetch stage's PC-select, target and stall/flush controls, and holds the ID/EX pipeline register that feeds execute.

## Interface
Parameters:
- RESET_PC, 32'h00003000, value loaded into PC2 on reset/bubble

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- PC1  in  32  PC of the instruction in IF/ID
- Instr1  in  32  instruction in IF/ID
- IntReq  in  1  interrupt/exception request
- RegWrite_W, A3_W[4:0], WD_W[31:0]  in  writeback port
- RegWrite_E, MemRead_E, A3_E[4:0]  in  EX-stage destination info
- RegWrite_M, MemRead_M, A3_M[4:0], ALURes_M[31:0]  in  M-stage destination info and forward value
- PCSel  out  3  000 seq, 001 beq taken, 010 j/jal, 011 jr, 101 exception vector, 111 eret
- PC_beq, PC_j, PC_jr  out  32  branch/jump targets
- PC_En, IF_ID_En, IF_ID_Clr  out  1  fetch-stage enables/flush
- PC2, Instr2, RD1_2, RD2_2, Ext2, PC8_2  out  32  ID/EX register
- A3_2  out  5  destination register; 0 = none
- RegWrite2, MemRead2, MemWrite2  out  1  ID/EX control bits

## Operation
- Supported opcodes: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, eret. Anything else decodes as nop, with all control bits 0 and A3 = 0.
- Ext2 is built per opcode:
  - ori: zero-extended imm16.
  - lui: {imm16, 16'b0}.
  - lw/sw/beq: sign-extended imm16.
- Destination register A3 by opcode:
  - rd for addu/subu.
  - rt for ori/lui/lw.
  - 31 for jal.
  - 0 otherwise.
- PC8_2 = PC1+8 (jal link value). Branches and jumps use delay slots, so IF/ID is not flushed for them.
- GPR file:
  - $0 reads 0 and writes to it are ignored.
  - Write-through: a same-cycle read of A3_W with RegWrite_W=1 returns WD_W.
- ID operand (rs/rt) source, in priority order:
  - M forward: RegWrite_M & !MemRead_M & A3_M==reg & reg≠0.
  - Otherwise the GPR read (including write-through).
- Targets (all 32-bit wrap):
  - PC_beq = PC1+4+(sext(imm16)<<2).
  - PC_j = {PC1[31:28], instr_index, 2'b00}.
  - PC_jr = forwarded rs.
- Stall is asserted when any of these hold:
  - (a) the instruction reads a reg (nonzero) that matches A3_E with MemRead_E.
  - (b) beq/jr reads a reg matching A3_E with RegWrite_E.
  - (c) beq/jr reads a reg matching A3_M with MemRead_M.
- When stalled: PC_En=0, IF_ID_En=0, PCSel=000, and a bubble is loaded into ID/EX. Otherwise PC_En=IF_ID_En=1.
- PCSel priority: IntReq → 101; else stall → 000; else eret → 111 with IF_ID_Clr=1; else beq with equal operands → 001; j/jal → 010; jr → 011; else 000.
- IF_ID_Clr is 1 only for a non-stalled eret in ID.
- ID/EX update priority at each edge: reset (async) > IntReq (bubble) > stall (bubble) > load decoded instruction.
- Bubble contents: all fields 0, except PC2 = RESET_PC.

## Timing
- Combinational, same cycle as Instr1: PCSel, targets, PC_En, IF_ID_En, IF_ID_Clr.
- Registered: ID/EX outputs are valid one cycle after the instruction sits in IF/ID. GPR writes land on the rising edge.
- Reset values, from reset falling, independent of clk:
  - All GPRs 0.
  - All ID/EX outputs 0, except PC2 = RESET_PC.
- Reset release takes effect at the next rising edge.
- Stall lasts exactly one cycle for (a), (b) and (c) individually; a (b)-then-(c) chain lasts 2 cycles.
- Writeback and read of the same register in the same cycle returns the new value; there is no extra stall.
- IntReq together with stall: PCSel=101, and ID/EX gets a bubble.
- IntReq together with a taken beq: PCSel=101; the branch is dropped.
- Reset asserted mid-stall: ID/EX clears immediately; no stall state is retained, because the stall is purely combinational.

## Test plan
- Reset pulse, then lw $1,0($0) in IF/ID -> at reset: RD1_2=0, PC2=0x3000. After one edge: A3_2=1, MemRead2=1, RegWrite2=1.
- WB writes $5=0x1234 while addu $6,$5,$0 is in ID -> RD1_2=0x1234 on the same edge. Separately, a write to $0 -> $0 still reads 0.
- beq $2,$3,+4 with PC1=0x3010, where $2 is forwarded from M as 7 and $3=7 -> PCSel=001, PC_beq=0x3024, IF_ID_Clr=0.
- lw $4 in EX with addu $7,$4,$4 in ID -> exactly one cycle of PC_En=0, IF_ID_En=0 and a bubble in ID/EX, then normal decode.
- jr $31 where $31 is written by the EX instruction -> 1-cycle stall, then PCSel=011, PC_jr = value forwarded from M.
- eret in ID -> PCSel=111, IF_ID_Clr=1. IntReq=1 with a taken beq -> PCSel=101 and ID/EX bubble (A3_2=0, RegWrite2=0).
